// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: thermometer stall vector, prioritised flush
// issue with deferral while frozen, debug halt/drain/resume FSM, event counters.
module pipe_ctrl_gen #(
    parameter int STAGES = 5,
    parameter int ADDR_W = 32,
    parameter int SW     = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic              stall_all_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              redirect_i,
    input  logic [SW-1:0]     redirect_stage_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    input  logic              haltreq_i,
    input  logic              resumereq_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              flush_valid_o,
    output logic [ADDR_W-1:0] flush_addr_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t              state;
    logic [SW-1:0]       drain_cnt;
    logic                pend_valid;
    logic                pend_int;
    logic [SW-1:0]       pend_stage;
    logic [ADDR_W-1:0]   pend_addr;

    logic [STAGES-1:0]   stall_raw;
    logic                frozen;
    logic                cur_redir_ok;
    logic                cur_valid;
    logic                cur_int;
    logic [SW-1:0]       cur_stage;
    logic [ADDR_W-1:0]   cur_addr;
    logic                pend_beats;
    logic                win_int;
    logic [SW-1:0]       win_stage;
    logic [ADDR_W-1:0]   win_addr;
    logic [STAGES-1:0]   kill;
    logic                issue;
    logic                drain_idle;

    // Bit i holds when any stage at index >= i requests a stall.
    always_comb begin
        stall_raw = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            stall_raw[j] = |(stallreq_i >> j);
        end
        if (state == DRAIN) stall_raw[0] = 1'b1;
        if (stall_all_i || state == HALTED) stall_raw = '1;
    end

    assign frozen = &stall_raw;

    always_comb begin
        cur_redir_ok = redirect_i && (redirect_stage_i != '0) && (32'(redirect_stage_i) < STAGES);
        cur_valid    = int_assert_i || cur_redir_ok;
        cur_int      = int_assert_i;
        cur_stage    = int_assert_i ? '0 : redirect_stage_i;
        cur_addr     = int_assert_i ? int_addr_i : redirect_addr_i;
    end

    // Pending only wins when strictly stronger; ties go to the newer request.
    always_comb begin
        pend_beats = pend_valid && (!cur_valid || (pend_int && !cur_int) ||
                                    (!pend_int && !cur_int && pend_stage > cur_stage));
        win_int    = pend_beats ? pend_int   : cur_int;
        win_stage  = pend_beats ? pend_stage : cur_stage;
        win_addr   = pend_beats ? pend_addr  : cur_addr;
        kill       = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            kill[j] = win_int || (j < 32'(win_stage));
        end
    end

    assign issue      = rst_n && (pend_valid || cur_valid) && !frozen && (state != HALTED);
    assign drain_idle = (stallreq_i == '0) && !stall_all_i && !pend_valid && !issue;

    assign stall_o       = rst_n ? stall_raw : '0;
    assign flush_valid_o = issue;
    assign flush_o       = issue ? kill : '0;
    assign flush_addr_o  = issue ? win_addr : '0;
    assign halted_o      = rst_n && (state == HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            pend_valid  <= 1'b0;
            pend_int    <= 1'b0;
            pend_stage  <= '0;
            pend_addr   <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o != '0) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (issue)         flush_cnt_o <= flush_cnt_o + CNT_W'(1);

            if (issue) begin
                pend_valid <= 1'b0;
            end else if (cur_valid) begin
                pend_valid <= 1'b1;
                pend_int   <= win_int;
                pend_stage <= win_stage;
                pend_addr  <= win_addr;
            end

            case (state)
                RUN: begin
                    if (haltreq_i) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!haltreq_i) begin
                        state <= RUN;
                    end else if (drain_idle) begin
                        drain_cnt <= drain_cnt + SW'(1);
                        if (32'(drain_cnt) + 32'd1 == 32'(STAGES - 1)) state <= HALTED;
                    end else begin
                        drain_cnt <= '0;
                    end
                end
                HALTED: begin
                    if (resumereq_i) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
